// File: rtl/ps2_key_sequencer.sv
// Turns the raw PS/2 byte stream into one-shot Hit/Stand/Deal pulses, tracking
// make/break/extended prefixes, suppressing typematic repeats and abandoning stale prefixes.
module ps2_key_sequencer #(
    parameter logic [7:0]  H_CODE         = 8'h33,
    parameter logic [7:0]  S_CODE         = 8'h1B,
    parameter logic [7:0]  D_CODE         = 8'h23,
    parameter int unsigned PREFIX_TIMEOUT = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       hit_enable,
    input  logic       stand_enable,
    input  logic       deal_enable,
    output logic       hit_pressed,
    output logic       stand_pressed,
    output logic       deal_pressed,
    output logic [2:0] key_held,
    output logic [7:0] last_code,
    output logic       prefix_timeout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GOT_E0   = 2'd1;
    localparam logic [1:0] GOT_F0   = 2'd2;
    localparam logic [1:0] GOT_E0F0 = 2'd3;

    localparam logic [21:0] TIMEOUT_LAST = 22'(PREFIX_TIMEOUT - 1);

    logic [1:0]  state, state_next;
    logic [21:0] count, count_next;
    logic [2:0]  held_next;
    logic [2:0]  pulse_next;
    logic        timeout_next;

    always_comb begin
        state_next   = state;
        count_next   = count;
        held_next    = key_held;
        pulse_next   = 3'b000;
        timeout_next = 1'b0;

        if (received_data_en) begin
            count_next = '0;
            case (state)
                IDLE: begin
                    case (received_data)
                        8'hE0: state_next = GOT_E0;
                        8'hF0: state_next = GOT_F0;
                        8'hAA: held_next  = 3'b000;
                        8'hFA, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            // A set held bit marks a typematic repeat: no pulse, no change.
                            if (received_data == H_CODE) begin
                                if (!key_held[0]) begin
                                    held_next[0]  = 1'b1;
                                    pulse_next[0] = hit_enable;
                                end
                            end else if (received_data == S_CODE) begin
                                if (!key_held[1]) begin
                                    held_next[1]  = 1'b1;
                                    pulse_next[1] = stand_enable;
                                end
                            end else if (received_data == D_CODE) begin
                                if (!key_held[2]) begin
                                    held_next[2]  = 1'b1;
                                    pulse_next[2] = deal_enable;
                                end
                            end
                        end
                    endcase
                end
                GOT_F0: begin
                    if (received_data == H_CODE)      held_next[0] = 1'b0;
                    else if (received_data == S_CODE) held_next[1] = 1'b0;
                    else if (received_data == D_CODE) held_next[2] = 1'b0;
                    state_next = IDLE;
                end
                GOT_E0: begin
                    state_next = (received_data == 8'hF0) ? GOT_E0F0 : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (count == TIMEOUT_LAST) begin
                state_next   = IDLE;
                count_next   = '0;
                timeout_next = 1'b1;
            end else begin
                count_next = count + 22'd1;
            end
        end else begin
            count_next = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            key_held       <= 3'b000;
            last_code      <= 8'h00;
            hit_pressed    <= 1'b0;
            stand_pressed  <= 1'b0;
            deal_pressed   <= 1'b0;
            prefix_timeout <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            key_held       <= held_next;
            hit_pressed    <= pulse_next[0];
            stand_pressed  <= pulse_next[1];
            deal_pressed   <= pulse_next[2];
            prefix_timeout <= timeout_next;
            if (received_data_en)
                last_code <= received_data;
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed scenarios plus random byte streams,
// every cycle compared against a prefix-queue reference model.
module tb_ps2_key_sequencer;

    localparam int TO = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       hit_enable = 1'b0, stand_enable = 1'b0, deal_enable = 1'b0;
    logic       hit_pressed, stand_pressed, deal_pressed;
    logic [2:0] key_held;
    logic [7:0] last_code;
    logic       prefix_timeout;

    ps2_key_sequencer #(.PREFIX_TIMEOUT(TO)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .hit_enable(hit_enable), .stand_enable(stand_enable), .deal_enable(deal_enable),
        .hit_pressed(hit_pressed), .stand_pressed(stand_pressed), .deal_pressed(deal_pressed),
        .key_held(key_held), .last_code(last_code), .prefix_timeout(prefix_timeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Reference model: pending prefix bytes, held keys, cycles waited since the prefix.
    logic [7:0] pfx[$];
    logic [2:0] m_held = 3'b000;
    logic [7:0] m_last = 8'h00;
    int         m_wait = 0;
    logic [2:0] e_pulse;
    logic       e_to;
    int         hit_count, stand_count, deal_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int key_index(input logic [7:0] b);
        if (b == 8'h33) return 0;
        if (b == 8'h1B) return 1;
        if (b == 8'h23) return 2;
        return -1;
    endfunction

    task automatic model(input logic en, input logic [7:0] b);
        int k;
        logic [2:0] ena;
        ena = {deal_enable, stand_enable, hit_enable};
        e_pulse = 3'b000;
        e_to = 1'b0;
        k = key_index(b);
        if (en) begin
            m_last = b;
            m_wait = 0;
            if (pfx.size() == 0) begin
                if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
                else if (b == 8'hAA) m_held = 3'b000;
                else if (k >= 0 && !m_held[k]) begin
                    m_held[k] = 1'b1;
                    e_pulse[k] = ena[k];
                end
            end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
                if (b == 8'hF0) pfx.push_back(b);
                else pfx.delete();
            end else if (pfx.size() == 1) begin
                if (k >= 0) m_held[k] = 1'b0;
                pfx.delete();
            end else begin
                pfx.delete();
            end
        end else if (pfx.size() != 0) begin
            m_wait++;
            if (m_wait == TO) begin
                pfx.delete();
                m_wait = 0;
                e_to = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".pulses"}, {29'd0, deal_pressed, stand_pressed, hit_pressed}, {29'd0, e_pulse});
        check({ctx, ".key_held"}, {29'd0, key_held}, {29'd0, m_held});
        check({ctx, ".last_code"}, {24'd0, last_code}, {24'd0, m_last});
        check({ctx, ".prefix_timeout"}, {31'd0, prefix_timeout}, {31'd0, e_to});
    endtask

    // Called #1 after an active edge; applies one cycle of input and checks the result.
    task automatic step(input logic en, input logic [7:0] b);
        received_data_en = en;
        received_data = b;
        model(en, b);
        @(posedge CLOCK_50);
        #1;
        hit_count   += int'(hit_pressed);
        stand_count += int'(stand_pressed);
        deal_count  += int'(deal_pressed);
        compare_all(en ? "strobe" : "idle");
        received_data_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        pfx.delete();
        m_held = 3'b000;
        m_last = 8'h00;
        m_wait = 0;
        e_pulse = 3'b000;
        e_to = 1'b0;
        compare_all("reset");
        @(posedge CLOCK_50);
        #1;
        compare_all("reset_hold");
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        hit_count = 0;
        stand_count = 0;
        deal_count = 0;
    endtask

    initial begin
        logic [7:0] pool [9];
        logic [7:0] b;
        pool = '{8'h33, 8'h1B, 8'h23, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00};

        @(posedge CLOCK_50);
        #1;
        do_reset();

        // Hit with typematic repeats then release.
        hit_enable = 1'b1; stand_enable = 1'b0; deal_enable = 1'b0;
        clear_counts();
        send(8'h33);
        check("hit_held_after_make", {29'd0, key_held}, 32'd1);
        send(8'h33); send(8'h33); send(8'hF0); send(8'h33);
        check("hit_single_pulse", hit_count, 1);
        check("hit_released", {29'd0, key_held}, 32'd0);

        // Stand pressed while disabled, enable later, release and press again.
        clear_counts();
        send(8'h1B);
        stand_enable = 1'b1;
        send(8'h1B); send(8'hF0); send(8'h1B); send(8'h1B);
        check("stand_one_pulse", stand_count, 1);
        check("stand_held_end", {31'd0, key_held[1]}, 32'd1);

        // Extended make/break of deal code are ignored.
        deal_enable = 1'b1;
        clear_counts();
        send(8'hE0); send(8'h23); send(8'hE0); send(8'hF0); send(8'h23);
        check("ext_no_deal", deal_count, 0);
        check("ext_no_held", {31'd0, key_held[2]}, 32'd0);
        send(8'h23);
        check("deal_after_ext", deal_count, 1);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h1B);

        // Dangling F0 times out; next 33 is a make.
        clear_counts();
        send(8'hF0);
        repeat (TO + 2) step(1'b0, 8'h00);
        send(8'h33);
        check("hit_after_timeout", hit_count, 1);

        // Strobe on the exact expiry cycle wins.
        send(8'hF0);
        repeat (TO - 1) step(1'b0, 8'h00);
        send(8'h33);
        check("strobe_wins_release", {31'd0, key_held[0]}, 32'd0);

        // AA clears held keys.
        clear_counts();
        send(8'h33); send(8'h1B); send(8'hAA);
        check("aa_clears", {29'd0, key_held}, 32'd0);
        send(8'h33);
        check("hit_after_aa", hit_count, 2);
        send(8'hAA);

        // Reset mid-prefix discards it.
        clear_counts();
        send(8'hF0);
        do_reset();
        send(8'h23);
        check("deal_after_reset", deal_count, 1);

        // Random streams.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 10) begin
                hit_enable   = 1'($urandom_range(0, 1));
                stand_enable = 1'($urandom_range(0, 1));
                deal_enable  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 99) < 4) begin
                repeat ($urandom_range(TO - 2, TO + 2)) step(1'b0, 8'h00);
            end else if ($urandom_range(0, 99) < 65) begin
                if ($urandom_range(0, 9) == 0) b = 8'($urandom);
                else b = pool[$urandom_range(0, 8)];
                send(b);
            end else begin
                step(1'b0, 8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the raw PS/2 byte stream from `PS2_Controller` into clean blackjack command pulses. It tracks the scan-code protocol (make, `F0` break, `E0` extended prefixes) and suppresses typematic repeats so that one physical press yields exactly one command. It also gates each command with a per-command enable from the game FSM. It sits between `PS2_Controller` and the game control logic, and replaces direct decoding of `received_data`.

## Interface
- `H_CODE`, 8'h33, make code for Hit
- `S_CODE`, 8'h1B, make code for Stand
- `D_CODE`, 8'h23, make code for Deal
- `PREFIX_TIMEOUT`, 2_500_000, CLOCK_50 cycles (50 ms) allowed between a prefix byte and its following byte; legal range 2 .. 2^22-1
- `CLOCK_50`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `received_data`  in  8  byte from `PS2_Controller`
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid in the same cycle
- `hit_enable`, `stand_enable`, `deal_enable`  in  1 each  command acceptance from the game FSM, sampled in the strobe cycle
- `hit_pressed`, `stand_pressed`, `deal_pressed`  out  1 each  one-cycle command pulses
- `key_held`  out  3  {deal, stand, hit}; 1 while that key is physically down
- `last_code`  out  8  last byte received (debug/LEDs)
- `prefix_timeout`  out  1  one-cycle pulse when a dangling prefix is abandoned

## Operation
- FSM states: `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`. Transitions happen only on a strobe or on a timeout.
- `IDLE` on strobe:
  - `E0` goes to `GOT_E0`.
  - `F0` goes to `GOT_F0`.
  - `AA` (BAT pass or hot-plug) clears all `key_held` bits and stays in `IDLE`.
  - `FA`, `FE`, `00`, `FF` are ignored.
  - Any other byte is a make code, and the state stays `IDLE`.
- Make code handling:
  - If it matches `H_CODE`, `S_CODE` or `D_CODE` and the corresponding `key_held` bit is 0, set the held bit. Pulse the command only if its enable is 1 in the strobe cycle.
  - If the held bit is already 1, the byte is a typematic repeat: no pulse, no change.
- `GOT_F0` on strobe: the byte is a break code. Clear the matching held bit (no effect if not held), then go to `IDLE`. No pulse is ever produced on a break.
- `GOT_E0` on strobe: `F0` goes to `GOT_E0F0`. Any other byte is an extended make: ignore it (even if it equals H/S/D code) and go to `IDLE`.
- `GOT_E0F0` on strobe: the byte is an extended break. Ignore it and go to `IDLE`.
- A press made while the command is disabled sets the held bit but produces no pulse. Asserting the enable later, while the key is still held, produces no pulse; the key must be released and pressed again.
- At most one command pulse is produced per strobe. Pulses are mutually exclusive by construction.
- `last_code` updates on every strobe, including prefixes and ignored bytes.
- Timeout counter (22 bits):
  - Cleared on every strobe and whenever the state is `IDLE`.
  - Increments each cycle in any non-`IDLE` state.
  - On reaching `PREFIX_TIMEOUT-1` with no strobe that cycle: return to `IDLE`, pulse `prefix_timeout`. `key_held` is unchanged.

## Timing
- Reset values: state `IDLE`, counter 0, all pulses 0, `key_held` 3'b000, `last_code` 8'h00.
- Reset is asynchronous. Asserting it mid-sequence (e.g. in `GOT_F0`) returns everything to reset values immediately. Held keys are forgotten.
- Latency: a command pulse is high in the cycle after the strobe cycle, for exactly 1 cycle. `key_held` and `last_code` update on the same edge.
- Back-to-back strobes on consecutive cycles must be handled. Each byte is processed against the state left by the previous byte.
- Strobe and timeout expiry in the same cycle: the strobe wins. The byte is processed in the current prefix state, the counter clears, and there is no `prefix_timeout` pulse.
- `prefix_timeout` is asserted the cycle after the expiry cycle, for 1 cycle.
- The enables affect only pulse generation, never `key_held` or FSM state.

## Test plan
- With `hit_enable`=1, send 33, 33, 33, F0, 33 -> exactly one `hit_pressed` pulse, 1 cycle after the first strobe. `key_held`=3'b001 after the first byte and 3'b000 after the final 33.
- With `stand_enable`=0, send 1B; then set `stand_enable`=1 and send 1B, F0, 1B, 1B -> `stand_pressed` pulses only on the last 1B, and `key_held[1]` ends at 1.
- Send E0, 23 and E0, F0, 23 with `deal_enable`=1 -> no `deal_pressed` and `key_held` stays 0. Then send 23 -> one pulse.
- Send F0, then no strobe for `PREFIX_TIMEOUT` cycles (with the parameter overridden to 16) -> `prefix_timeout` pulses once. A following 33 is then treated as a make and pulses `hit_pressed`.
- Hold 33 and 1B (both held), send AA -> `key_held`=3'b000. A following 33 pulses `hit_pressed` again.
- Send F0, assert `reset` for 1 cycle mid-stream, then send 23 -> `deal_pressed` pulses, since the prefix was discarded by reset. All outputs read reset values while `reset`=1.
